// File: rtl/mac_rx_parser_pkg.sv
// +--------------------------------------------------------------------------+
// | mac_pkg : shared constants and FSM state type for the MAC receive parser  |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

package mac_pkg;

   localparam int          ETH_HDR_LEN = 14;
   localparam int          ETH_FCS_LEN = 4;
   localparam logic [47:0] BCAST_ADDR  = 48'hFFFF_FFFF_FFFF;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_HDR      = 3'd1,
      ST_PAYLOAD  = 3'd2,
      ST_DRAIN    = 3'd3,
      ST_ACK      = 3'd4,
      ST_WAIT_CLR = 3'd5
   } rx_state_t;

endpackage

`default_nettype wire

// File: rtl/mac_rx_parser_if.sv
// +--------------------------------------------------------------------------+
// | mac_rx_parser_if : payload stream (valid/ready) from the MAC rx parser    |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

interface mac_rx_parser_if;

   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       out_err;

   modport master (output out_data, out_valid, out_last, out_err, input out_ready);
   modport slave  (input out_data, out_valid, out_last, out_err, output out_ready);

endinterface

`default_nettype wire

// File: rtl/mac_rx_byte_fifo.sv
// +--------------------------------------------------------------------------+
// | mac_rx_byte_fifo : small byte FIFO with occupancy output and flush        |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_rx_byte_fifo #(
   parameter int DEPTH = 8
) (
   input  wire                       clk,
   input  wire                       rst,
   input  wire                       clr,
   input  wire                       push,
   input  wire  [7:0]                din,
   input  wire                       pop,
   output logic [7:0]                dout,
   output logic [$clog2(DEPTH):0]    count
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    r_mem [DEPTH];
   logic [AW-1:0] r_wr_ptr;
   logic [AW-1:0] r_rd_ptr;
   logic [AW:0]   r_count;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else if (clr) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (push) begin
            r_mem[r_wr_ptr] <= din;
            r_wr_ptr        <= r_wr_ptr + AW'(1);
         end
         if (pop) r_rd_ptr <= r_rd_ptr + AW'(1);
         case ({push, pop})
            2'b10:   r_count <= r_count + (AW+1)'(1);
            2'b01:   r_count <= r_count - (AW+1)'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   assign dout  = r_mem[r_rd_ptr];
   assign count = r_count;

endmodule

`default_nettype wire

// File: rtl/mac_rx_parser.sv
// +--------------------------------------------------------------------------+
// | mac_rx_parser : drains mac_rx frames, filters on destination MAC and      |
// | streams the payload with FCS stripped; keeps good/dropped counters.       |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module mac_rx_parser
   import mac_pkg::*;
#(
   parameter logic [47:0] MAC_ADDR     = 48'h112233445566,
   parameter bit          ACCEPT_MCAST = 1'b1,
   parameter int          MIN_FRAME    = 64,
   parameter int          MAX_FRAME    = 1522
) (
   input  wire             clk,
   input  wire             rst,
   input  wire             frame_received,
   output logic            read_en,
   input  wire  [7:0]      rx_byte,
   input  wire             read_complete,
   output logic            frame_received_ack,
   input  wire             promisc,
   output logic            hdr_valid,
   output logic [47:0]     hdr_dst,
   output logic [47:0]     hdr_src,
   output logic [15:0]     hdr_type,
   mac_rx_parser_if.master st,
   output logic [15:0]     frames_ok,
   output logic [15:0]     frames_dropped
);

   localparam logic [10:0] C_CNT_SAT  = 11'(MAX_FRAME + 1);
   localparam logic [10:0] C_MIN      = 11'(MIN_FRAME);
   localparam logic [10:0] C_MAX      = 11'(MAX_FRAME);
   localparam logic [10:0] C_DST_LAST = 11'd5;
   localparam logic [10:0] C_HDR_LAST = 11'(ETH_HDR_LEN - 1);
   localparam logic [3:0]  C_POP_MIN  = 4'(ETH_FCS_LEN + 1);
   localparam logic [3:0]  C_FILL_MAX = 4'd6;

   rx_state_t    r_state;
   rx_state_t    w_state_nxt;
   logic         r_rd_q;
   logic [10:0]  r_cnt;
   logic [10:0]  w_cnt_nxt;
   logic [103:0] r_hdr_sh;
   logic         r_accept;
   logic         r_done;
   logic         r_err;
   logic         r_good;
   logic [47:0]  w_dst;
   logic         w_dst_hit;
   logic         w_cap;
   logic         w_end;
   logic         w_push;
   logic         w_pop;
   logic         w_fifo_clr;
   logic         w_out_valid;
   logic         w_out_last;
   logic [7:0]   w_fifo_dout;
   logic [3:0]   w_fifo_count;

   assign w_cap       = r_rd_q;
   assign w_end       = r_rd_q & read_complete;
   assign w_cnt_nxt   = (r_cnt == C_CNT_SAT) ? r_cnt : r_cnt + 11'd1;
   assign w_dst       = {r_hdr_sh[39:0], rx_byte};
   assign w_dst_hit   = promisc | (w_dst == MAC_ADDR) | (w_dst == BCAST_ADDR) |
                        (ACCEPT_MCAST & w_dst[40]);

   // The last four bytes in the FIFO are always the FCS, so pop only above that.
   assign w_out_valid = (r_state == ST_PAYLOAD) & (w_fifo_count >= C_POP_MIN);
   assign w_out_last  = w_out_valid & r_done & (w_fifo_count == C_POP_MIN);
   assign w_pop       = w_out_valid & st.out_ready;
   assign w_push      = (r_state == ST_PAYLOAD) & w_cap;
   assign w_fifo_clr  = (r_state == ST_ACK);

   assign st.out_valid       = w_out_valid;
   assign st.out_data        = w_out_valid ? w_fifo_dout : 8'd0;
   assign st.out_last        = w_out_last;
   assign st.out_err         = w_out_last & r_err;
   assign frame_received_ack = (r_state == ST_ACK);

   mac_rx_byte_fifo #(
      .DEPTH (8)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .clr   (w_fifo_clr),
      .push  (w_push),
      .din   (rx_byte),
      .pop   (w_pop),
      .dout  (w_fifo_dout),
      .count (w_fifo_count)
   );

   always_comb begin
      w_state_nxt = r_state;
      read_en     = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (frame_received) w_state_nxt = ST_HDR;
         end
         ST_HDR: begin
            read_en = ~w_end;
            if (w_cap && (r_cnt == C_HDR_LAST))
               w_state_nxt = r_accept ? ST_PAYLOAD : ST_DRAIN;
            else if (w_end)
               w_state_nxt = ST_DRAIN;
         end
         ST_PAYLOAD: begin
            // One byte may still be in flight, so keep two free slots per request.
            read_en = ~r_done & ~w_end & (w_fifo_count <= C_FILL_MAX);
            if ((w_pop && w_out_last) || (r_done && !w_out_valid))
               w_state_nxt = ST_ACK;
         end
         ST_DRAIN: begin
            read_en = ~r_done & ~w_end;
            if (r_done || w_end) w_state_nxt = ST_ACK;
         end
         ST_ACK: begin
            w_state_nxt = ST_WAIT_CLR;
         end
         ST_WAIT_CLR: begin
            if (!frame_received) w_state_nxt = ST_IDLE;
         end
         default: w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state        <= ST_IDLE;
         r_rd_q         <= 1'b0;
         r_cnt          <= '0;
         r_hdr_sh       <= '0;
         r_accept       <= 1'b0;
         r_done         <= 1'b0;
         r_err          <= 1'b0;
         r_good         <= 1'b0;
         hdr_valid      <= 1'b0;
         hdr_dst        <= '0;
         hdr_src        <= '0;
         hdr_type       <= '0;
         frames_ok      <= '0;
         frames_dropped <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_rd_q    <= read_en;
         hdr_valid <= 1'b0;
         if (r_state == ST_IDLE) begin
            r_cnt    <= '0;
            r_accept <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_good   <= 1'b0;
         end else begin
            if (w_cap) r_cnt <= w_cnt_nxt;
            if (w_cap && (r_cnt < C_HDR_LAST)) r_hdr_sh <= {r_hdr_sh[95:0], rx_byte};
            if ((r_state == ST_HDR) && w_cap && (r_cnt == C_DST_LAST)) r_accept <= w_dst_hit;
            if ((r_state == ST_HDR) && w_cap && (r_cnt == C_HDR_LAST) && r_accept) begin
               hdr_valid <= 1'b1;
               hdr_dst   <= r_hdr_sh[103:56];
               hdr_src   <= r_hdr_sh[55:8];
               hdr_type  <= {r_hdr_sh[7:0], rx_byte};
            end
            if (w_end) begin
               r_done <= 1'b1;
               r_err  <= (w_cnt_nxt < C_MIN) | (w_cnt_nxt > C_MAX);
            end
            if (w_pop && w_out_last && !r_err) r_good <= 1'b1;
         end
         if (r_state == ST_ACK) begin
            if (r_good) begin
               if (frames_ok != 16'hFFFF) frames_ok <= frames_ok + 16'd1;
            end else if (frames_dropped != 16'hFFFF) begin
               frames_dropped <= frames_dropped + 16'd1;
            end
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_mac_rx_parser.sv
// +--------------------------------------------------------------------------+
// | tb_mac_rx_parser : randomized frames against a frame-level reference      |
// | Rev 1.0 - initial release                                                 |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_mac_rx_parser;

   localparam logic [47:0] STATION = 48'h112233445566;

   logic        clk            = 1'b0;
   logic        rst            = 1'b0;
   logic        frame_received = 1'b0;
   logic        read_complete  = 1'b0;
   logic        promisc        = 1'b0;
   logic [7:0]  rx_byte        = 8'd0;
   logic        read_en;
   logic        frame_received_ack;
   logic        hdr_valid;
   logic [47:0] hdr_dst;
   logic [47:0] hdr_src;
   logic [15:0] hdr_type;
   logic [15:0] frames_ok;
   logic [15:0] frames_dropped;

   mac_rx_parser_if st_if ();

   mac_rx_parser #(
      .MAC_ADDR     (STATION),
      .ACCEPT_MCAST (1'b1),
      .MIN_FRAME    (64),
      .MAX_FRAME    (1522)
   ) dut (
      .clk                (clk),
      .rst                (rst),
      .frame_received     (frame_received),
      .read_en            (read_en),
      .rx_byte            (rx_byte),
      .read_complete      (read_complete),
      .frame_received_ack (frame_received_ack),
      .promisc            (promisc),
      .hdr_valid          (hdr_valid),
      .hdr_dst            (hdr_dst),
      .hdr_src            (hdr_src),
      .hdr_type           (hdr_type),
      .st                 (st_if),
      .frames_ok          (frames_ok),
      .frames_dropped     (frames_dropped)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_fail   = 0;
   logic [7:0]  frm [0:1599];
   int          len = 0;
   int          ptr = 0;
   bit          frame_active = 1'b0;
   bit          cur_accept   = 1'b0;
   int          rdy_mode = 0;
   int          cyc = 0;
   logic [7:0]  got_data [$];
   bit          got_last [$];
   bit          got_err  [$];
   int          hdr_cnt = 0;
   int          ack_cnt = 0;
   logic [47:0] got_dst = '0;
   logic [47:0] got_src = '0;
   logic [15:0] got_type = '0;
   int          exp_ok = 0;
   int          exp_drop = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // mac_rx stand-in: a request seen in cycle k puts the next byte on rx_byte in k+1
   initial begin : p_mac_rx
      bit rd_req;
      bit ended;
      ended = 1'b1;
      forever begin
         @(negedge clk);
         rd_req = read_en;
         if (rst && ended) check_eq("rd_after_end", 64'(rd_req), 64'd0);
         ended = (ptr >= len);
         @(posedge clk);
         #1;
         if (rd_req && (ptr < len)) begin
            rx_byte       = frm[ptr];
            read_complete = (ptr == len - 1);
            ptr++;
         end else begin
            read_complete = 1'b0;
         end
      end
   end

   initial begin : p_ready
      st_if.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         cyc++;
         case (rdy_mode)
            0:       st_if.out_ready = 1'b1;
            1:       st_if.out_ready = 1'($urandom_range(0, 1));
            default: st_if.out_ready = ((cyc % 3) == 0);
         endcase
      end
   end

   initial begin : p_monitor
      bit         pv;
      bit         pr;
      logic [7:0] pd;
      int         occ;
      pv = 1'b0;
      pr = 1'b0;
      pd = '0;
      forever begin
         @(negedge clk);
         if (rst) begin
            if (pv && !pr) begin
               check_eq("hold_valid", 64'(st_if.out_valid), 64'd1);
               check_eq("hold_data", 64'(st_if.out_data), 64'(pd));
            end
            if (frame_active && cur_accept && (ptr > 14)) begin
               occ = ptr - 14 - got_data.size();
               check_eq("fifo_bound", 64'(occ <= 8), 64'd1);
            end
            if (st_if.out_valid && st_if.out_ready) begin
               got_data.push_back(st_if.out_data);
               got_last.push_back(st_if.out_last);
               got_err.push_back(st_if.out_err);
            end
            if (hdr_valid) begin
               hdr_cnt++;
               got_dst  = hdr_dst;
               got_src  = hdr_src;
               got_type = hdr_type;
            end
            if (frame_received_ack) ack_cnt++;
         end
         pv = st_if.out_valid & rst;
         pr = st_if.out_ready;
         pd = st_if.out_data;
      end
   end

   task automatic check_reset_state(input string pfx);
      check_eq({pfx, "_read_en"}, 64'(read_en), 64'd0);
      check_eq({pfx, "_ack"}, 64'(frame_received_ack), 64'd0);
      check_eq({pfx, "_hdr_valid"}, 64'(hdr_valid), 64'd0);
      check_eq({pfx, "_hdr_dst"}, 64'(hdr_dst), 64'd0);
      check_eq({pfx, "_hdr_src"}, 64'(hdr_src), 64'd0);
      check_eq({pfx, "_hdr_type"}, 64'(hdr_type), 64'd0);
      check_eq({pfx, "_out_valid"}, 64'(st_if.out_valid), 64'd0);
      check_eq({pfx, "_out_data"}, 64'(st_if.out_data), 64'd0);
      check_eq({pfx, "_out_last"}, 64'(st_if.out_last), 64'd0);
      check_eq({pfx, "_out_err"}, 64'(st_if.out_err), 64'd0);
      check_eq({pfx, "_frames_ok"}, 64'(frames_ok), 64'd0);
      check_eq({pfx, "_frames_dropped"}, 64'(frames_dropped), 64'd0);
   endtask

   // kind: 0 station address, 1 broadcast, 2 multicast, 3 foreign unicast
   task automatic build_frame(input int n, input int kind);
      logic [47:0] sta;
      sta = STATION;
      for (int i = 0; i < n; i++) frm[i] = 8'($urandom);
      case (kind)
         0:       for (int i = 0; i < 6; i++) frm[i] = sta[47 - 8*i -: 8];
         1:       for (int i = 0; i < 6; i++) frm[i] = 8'hFF;
         2:       frm[0][0] = 1'b1;
         default: frm[0][0] = 1'b0;
      endcase
      len = n;
   endtask

   task automatic run_frame(input bit prom, input int mode, input int hold);
      logic [47:0] dst;
      bit          acc;
      bit          err;
      int          npay;
      int          nchk;
      dst  = {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]};
      acc  = (len >= 14) && (prom || (dst == STATION) || (dst == 48'hFFFF_FFFF_FFFF) || dst[40]);
      npay = (acc && (len >= 19)) ? len - 18 : 0;
      err  = (len < 64) || (len > 1522);
      if ((npay > 0) && !err) exp_ok++;
      else exp_drop++;

      @(posedge clk);
      #1;
      got_data.delete();
      got_last.delete();
      got_err.delete();
      hdr_cnt        = 0;
      ack_cnt        = 0;
      promisc        = prom;
      rdy_mode       = mode;
      cur_accept     = acc;
      ptr            = 0;
      frame_active   = 1'b1;
      frame_received = 1'b1;
      for (int i = 0; (i < 8000) && (ack_cnt == 0); i++) @(negedge clk);
      frame_active = 1'b0;
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         check_eq("hold_no_read", 64'(read_en), 64'd0);
      end
      @(posedge clk);
      #1;
      frame_received = 1'b0;
      repeat (3) @(negedge clk);

      check_eq("ack_cnt", 64'(ack_cnt), 64'd1);
      check_eq("hdr_cnt", 64'(hdr_cnt), 64'(acc));
      if (acc) begin
         check_eq("hdr_dst", 64'(got_dst), 64'(dst));
         check_eq("hdr_src", 64'(got_src), 64'({frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]}));
         check_eq("hdr_type", 64'(got_type), 64'({frm[12], frm[13]}));
      end
      check_eq("pay_len", 64'(got_data.size()), 64'(npay));
      nchk = (got_data.size() < npay) ? got_data.size() : npay;
      for (int i = 0; i < nchk; i++) begin
         check_eq("pay_data", 64'(got_data[i]), 64'(frm[14 + i]));
         check_eq("pay_last", 64'(got_last[i]), 64'(i == npay - 1));
         if (i == npay - 1) check_eq("pay_err", 64'(got_err[i]), 64'(err));
      end
      check_eq("frames_ok", 64'(frames_ok), 64'(exp_ok));
      check_eq("frames_dropped", 64'(frames_dropped), 64'(exp_drop));
   endtask

   initial begin : p_main
      int short_lens [10];
      int n;
      short_lens = '{5, 13, 14, 15, 18, 19, 20, 63, 64, 65};

      repeat (3) @(negedge clk);
      check_reset_state("rst");
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);

      // short frame from the station address: streamed but flagged as runt
      build_frame(22, 0);
      {frm[6], frm[7], frm[8], frm[9], frm[10], frm[11]} = 48'h7788_99AA_BBCC;
      {frm[12], frm[13]} = 16'h0800;
      for (int i = 0; i < 4; i++) frm[14 + i] = 8'(i + 1);
      {frm[18], frm[19], frm[20], frm[21]} = 32'h7470_29FC;
      run_frame(1'b0, 0, 0);

      build_frame(64, 0);
      for (int i = 0; i < 46; i++) frm[14 + i] = 8'(i);
      run_frame(1'b0, 0, 0);

      build_frame(64, 3);
      {frm[0], frm[1], frm[2], frm[3], frm[4], frm[5]} = 48'h0000_0000_0001;
      run_frame(1'b0, 1, 0);
      run_frame(1'b1, 1, 0);

      build_frame(100, 1);
      run_frame(1'b0, 2, 0);

      for (int i = 0; i < 10; i++) begin
         build_frame(short_lens[i], 0);
         run_frame(1'b0, 1, 0);
      end
      build_frame(1522, 2);
      run_frame(1'b0, 0, 0);
      build_frame(1523, 0);
      run_frame(1'b0, 0, 0);
      build_frame(1530, 1);
      run_frame(1'b0, 0, 0);

      for (int i = 0; i < 30; i++) begin
         n = ($urandom_range(0, 2) == 0) ? short_lens[$urandom_range(0, 9)] : int'($urandom_range(20, 200));
         build_frame(n, int'($urandom_range(0, 3)));
         run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 2)), 0);
      end

      // frame_received left high after the ack must not start another read
      build_frame(80, 0);
      run_frame(1'b0, 0, 12);
      build_frame(70, 1);
      run_frame(1'b0, 1, 0);

      // reset in the middle of a payload
      build_frame(300, 1);
      @(posedge clk);
      #1;
      got_data.delete();
      got_last.delete();
      got_err.delete();
      rdy_mode       = 0;
      cur_accept     = 1'b1;
      ptr            = 0;
      frame_active   = 1'b1;
      frame_received = 1'b1;
      for (int i = 0; (i < 2000) && (got_data.size() < 3); i++) @(negedge clk);
      check_eq("pre_rst_stream", 64'(got_data.size() >= 3), 64'd1);
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      check_reset_state("midrst");
      frame_active   = 1'b0;
      frame_received = 1'b0;
      ptr            = len;
      exp_ok         = 0;
      exp_drop       = 0;
      @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (2) @(negedge clk);
      build_frame(90, 0);
      run_frame(1'b0, 0, 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

`default_nettype wire
